// File: rtl/alu_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_ctrl_pkg : opcode/condition constants, flag indices, FSM states and  |
// | opcode classification shared by the ALU issue controller.  Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_ctrl_pkg;

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_EOR = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_RSB = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_TST = 5'b01000;
    localparam logic [4:0] OP_TEQ = 5'b01001;
    localparam logic [4:0] OP_CMP = 5'b01010;
    localparam logic [4:0] OP_CMN = 5'b01011;
    localparam logic [4:0] OP_ORR = 5'b01100;
    localparam logic [4:0] OP_MOV = 5'b01101;
    localparam logic [4:0] OP_BIC = 5'b01110;
    localparam logic [4:0] OP_MVN = 5'b01111;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_WB   = 2'd2;

    // Compare/test ops set flags unconditionally and never write a register.
    function automatic logic is_compare(input logic [4:0] op);
        logic res;
        res = 1'b0;
        case (op)
            OP_TST, OP_TEQ, OP_CMP, OP_CMN: res = 1'b1;
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_arith(input logic [4:0] op);
        logic res;
        res = 1'b0;
        case (op)
            OP_SUB, OP_RSB, OP_ADD, OP_CMP, OP_CMN: res = 1'b1;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        logic res;
        res = 1'b0;
        case (op)
            OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD,
            OP_TST, OP_TEQ, OP_CMP, OP_CMN,
            OP_ORR, OP_MOV, OP_BIC, OP_MVN:     res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cond_check.sv
// +--------------------------------------------------------------------------+
// | cond_check : evaluates an ARM condition field against NZCV flags.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module cond_check
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic w_z;
    logic w_c;
    logic w_n;
    logic w_v;

    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_n = flags[FLAG_N];
    assign w_v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = w_z;
            COND_NE: pass = ~w_z;
            COND_CS: pass = w_c;
            COND_CC: pass = ~w_c;
            COND_MI: pass = w_n;
            COND_PL: pass = ~w_n;
            COND_VS: pass = w_v;
            COND_VC: pass = ~w_v;
            COND_HI: pass = w_c & ~w_z;
            COND_LS: pass = ~w_c | w_z;
            COND_GE: pass = (w_n == w_v);
            COND_LT: pass = (w_n != w_v);
            COND_GT: pass = ~w_z & (w_n == w_v);
            COND_LE: pass = w_z | (w_n != w_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// +--------------------------------------------------------------------------+
// | alu_issue_ctrl : IDLE->EXEC->WB sequencer in front of a combinational    |
// | ALU; owns NZCV, drives the ALU and the register-file write port. Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_cond,
    input  logic [4:0]            in_opcode,
    input  logic                  in_setflags,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]     in_op1,
    input  logic [DATA_W-1:0]     in_op2,

    input  logic                  flush,
    input  logic                  cpsr_we,
    input  logic [3:0]            cpsr_wdata,

    output logic                  alu_execute,
    output logic [DATA_W-1:0]     alu_data1,
    output logic [DATA_W-1:0]     alu_data2,
    output logic [4:0]            alu_operation,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [3:0]            alu_flags,

    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic [3:0]            cpsr_flags,
    output logic                  skipped,
    output logic                  illegal
);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [3:0]            r_cond;
    logic [4:0]            r_opcode;
    logic                  r_setflags;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]     r_op1;
    logic [DATA_W-1:0]     r_op2;

    logic [DATA_W-1:0]     r_result;
    logic [3:0]            r_res_flags;
    logic                  r_pass;
    logic                  r_illegal;
    logic [3:0]            r_cpsr;

    logic                  w_accept;
    logic                  w_pass;
    logic                  w_legal;
    logic                  w_wb_live;
    logic                  w_commit;
    logic                  w_flag_upd;
    logic [3:0]            w_flags_nxt;

    cond_check u_cond_check (
        .cond  (r_cond),
        .flags (r_cpsr),
        .pass  (w_pass)
    );

    assign w_legal  = is_legal(r_opcode);
    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_ready & in_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = in_valid ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_state_nxt = flush    ? ST_IDLE : ST_WB;
            ST_WB:   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // WB side effects are gated by flush combinationally so an abort in the
    // WB cycle itself still suppresses the write and the status pulses.
    assign w_wb_live  = (r_state == ST_WB) & ~flush;
    assign w_commit   = w_wb_live & ~r_illegal & r_pass;
    assign wb_en      = w_commit & ~is_compare(r_opcode);
    assign illegal    = w_wb_live & r_illegal;
    assign skipped    = w_wb_live & ~r_illegal & ~r_pass;
    assign w_flag_upd = w_commit & (is_compare(r_opcode) | r_setflags);

    always_comb begin
        w_flags_nxt         = r_cpsr;
        w_flags_nxt[FLAG_N] = r_res_flags[FLAG_N];
        w_flags_nxt[FLAG_Z] = r_res_flags[FLAG_Z];
        if (is_arith(r_opcode)) begin
            w_flags_nxt[FLAG_C] = r_res_flags[FLAG_C];
            w_flags_nxt[FLAG_V] = r_res_flags[FLAG_V];
        end
    end

    assign alu_execute   = (r_state == ST_EXEC) & w_pass & w_legal;
    assign alu_data1     = r_op1;
    assign alu_data2     = r_op2;
    assign alu_operation = r_opcode;
    assign wb_addr       = r_rd;
    assign wb_data       = r_result;
    assign cpsr_flags    = r_cpsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cond      <= '0;
            r_opcode    <= '0;
            r_setflags  <= 1'b0;
            r_rd        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_result    <= '0;
            r_res_flags <= '0;
            r_pass      <= 1'b0;
            r_illegal   <= 1'b0;
            r_cpsr      <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_cond     <= in_cond;
                r_opcode   <= in_opcode;
                r_setflags <= in_setflags;
                r_rd       <= in_rd;
                r_op1      <= in_op1;
                r_op2      <= in_op2;
            end

            if (r_state == ST_EXEC) begin
                r_result    <= alu_result;
                r_res_flags <= alu_flags;
                r_pass      <= w_pass;
                r_illegal   <= ~w_legal;
            end

            // A direct MSR-style load overrides any same-cycle flag update.
            if (cpsr_we) begin
                r_cpsr <= cpsr_wdata;
            end else if (w_flag_upd) begin
                r_cpsr <= w_flags_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: bench-side ALU model, NZCV reference model,
// directed steps followed by randomized instructions.
`default_nettype none
`timescale 1ns/1ps

module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic [4:0]  in_opcode;
    logic        in_setflags;
    logic [3:0]  in_rd;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic        flush;
    logic        cpsr_we;
    logic [3:0]  cpsr_wdata;
    logic        alu_execute;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [4:0]  alu_operation;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  cpsr_flags;
    logic        skipped;
    logic        illegal;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  mflags;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(32), .REG_ADDR_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cond       (in_cond),
        .in_opcode     (in_opcode),
        .in_setflags   (in_setflags),
        .in_rd         (in_rd),
        .in_op1        (in_op1),
        .in_op2        (in_op2),
        .flush         (flush),
        .cpsr_we       (cpsr_we),
        .cpsr_wdata    (cpsr_wdata),
        .alu_execute   (alu_execute),
        .alu_data1     (alu_data1),
        .alu_data2     (alu_data2),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .cpsr_flags    (cpsr_flags),
        .skipped       (skipped),
        .illegal       (illegal)
    );

    // Add or subtract with flags from wide signed/unsigned arithmetic; returns {V,N,C,Z,result}.
    function automatic logic [35:0] addsub(input logic [31:0] a, input logic [31:0] b, input bit sub);
        longint     sa;
        longint     sb;
        longint     s;
        logic [63:0] us;
        logic [31:0] r;
        logic        c;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = sub ? (sa - sb) : (sa + sb);
        us = 64'(a) + 64'(b);
        r  = sub ? (a - b) : (a + b);
        c  = sub ? (a >= b) : (us > 64'hFFFF_FFFF);
        v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {v, r[31], c, (r == 32'd0), r};
    endfunction

    function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            5'd2:  return addsub(a, b, 1'b1);
            5'd3:  return addsub(b, a, 1'b1);
            5'd4:  return addsub(a, b, 1'b0);
            5'd10: return addsub(a, b, 1'b1);
            5'd11: return addsub(a, b, 1'b0);
            5'd0, 5'd8:  r = a & b;
            5'd1, 5'd9:  r = a ^ b;
            5'd12: r = a | b;
            5'd13: r = b;
            5'd14: r = a & ~b;
            5'd15: r = ~b;
            default: r = 32'd0;
        endcase
        return {1'b0, r[31], 1'b0, (r == 32'd0), r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_operation, alu_data1, alu_data2);

    function automatic bit cond_model(input logic [3:0] cond, input logic [3:0] f);
        bit z, c, n, v, base;
        z = f[0]; c = f[1]; n = f[2]; v = f[3];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'd14) return 1'b1;
        if (cond == 4'd15) return 1'b0;
        return cond[0] ? !base : base;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // fl: 0 none, 1 flush during accept, 2 flush in EXEC, 3 flush in WB.
    task automatic issue(input logic [3:0] cond, input logic [4:0] opc, input bit s,
                         input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                         input int fl, input bit we, input logic [3:0] wd);
        logic [35:0] ax;
        bit legal, pass, cmp, arith, wr, upd;
        ax    = alu_model(opc, a, b);
        legal = (opc <= 5'd4) || (opc >= 5'd8 && opc <= 5'd15);
        cmp   = (opc >= 5'd8 && opc <= 5'd11);
        arith = (opc == 5'd2) || (opc == 5'd3) || (opc == 5'd4) || (opc == 5'd10) || (opc == 5'd11);
        pass  = cond_model(cond, mflags);
        wr    = legal && pass && !cmp;

        check("ready_idle", in_ready, 1);
        in_valid = 1'b1; in_cond = cond; in_opcode = opc; in_setflags = s;
        in_rd = rd; in_op1 = a; in_op2 = b; flush = (fl == 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        in_op1 = $urandom; in_op2 = $urandom; in_opcode = 5'($urandom); in_rd = 4'($urandom);

        check("ready_exec", in_ready, 0);
        check("alu_execute", alu_execute, legal && pass);
        check("alu_data1", alu_data1, a);
        check("alu_data2", alu_data2, b);
        check("alu_operation", alu_operation, opc);

        if (fl == 2) begin
            flush = 1'b1;
            @(posedge clk); @(negedge clk);
            flush = 1'b0;
            check("flush_exec_ready", in_ready, 1);
            check("flush_exec_wb_en", wb_en, 0);
            check("flush_exec_flags", cpsr_flags, mflags);
            return;
        end

        @(posedge clk); @(negedge clk);
        if (fl == 3) begin
            flush = 1'b1;
            #1;
            check("flush_wb_wb_en", wb_en, 0);
            check("flush_wb_skipped", skipped, 0);
            check("flush_wb_illegal", illegal, 0);
        end else begin
            check("wb_en", wb_en, wr);
            check("skipped", skipped, legal && !pass);
            check("illegal", illegal, !legal);
            check("ready_wb", in_ready, 0);
            if (wr) begin
                check("wb_addr", wb_addr, rd);
                check("wb_data", wb_data, ax[31:0]);
            end
        end
        cpsr_we = we; cpsr_wdata = wd;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; cpsr_we = 1'b0;

        upd = legal && pass && (cmp || s) && (fl != 3);
        if (we) begin
            mflags = wd;
        end else if (upd) begin
            mflags[0] = ax[32];
            mflags[2] = ax[34];
            if (arith) begin
                mflags[1] = ax[33];
                mflags[3] = ax[35];
            end
        end
        check("cpsr_flags", cpsr_flags, mflags);
        check("ready_back", in_ready, 1);
        check("wb_en_idle", wb_en, 0);
    endtask

    task automatic load_flags(input logic [3:0] wd);
        cpsr_we = 1'b1; cpsr_wdata = wd;
        @(posedge clk); @(negedge clk);
        cpsr_we = 1'b0;
        mflags = wd;
        check("cpsr_load", cpsr_flags, mflags);
    endtask

    logic [4:0] legal_ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9,
                                   5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  ropc;
        logic [3:0]  rcond;
        int          rfl;
        rst_n = 1'b0; in_valid = 1'b0; in_cond = 4'd0; in_opcode = 5'd0; in_setflags = 1'b0;
        in_rd = 4'd0; in_op1 = 32'd0; in_op2 = 32'd0; flush = 1'b0; cpsr_we = 1'b0; cpsr_wdata = 4'd0;
        mflags = 4'd0;
        @(negedge clk); @(negedge clk);

        check("rst_in_ready", in_ready, 1);
        check("rst_cpsr", cpsr_flags, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_alu_execute", alu_execute, 0);
        check("rst_alu_data1", alu_data1, 0);
        check("rst_alu_data2", alu_data2, 0);
        check("rst_alu_operation", alu_operation, 0);
        check("rst_skipped", skipped, 0);
        check("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'hE, 5'd4, 1, 4'd2, 32'd3, 32'd7, 0, 0, 4'd0);           // ADDS 3+7
        check("add_flags", cpsr_flags, 4'b0000);
        issue(4'hE, 5'd10, 0, 4'd0, 32'd7, 32'd7, 0, 0, 4'd0);          // CMP 7,7
        check("cmp_flags", cpsr_flags, 4'b0011);
        issue(4'h0, 5'd13, 0, 4'd5, 32'd0, 32'h55, 0, 0, 4'd0);         // MOVEQ
        issue(4'h1, 5'd13, 0, 4'd5, 32'd0, 32'h66, 0, 0, 4'd0);         // MOVNE skipped
        issue(4'hE, 5'd2, 1, 4'd1, 32'd3, 32'd7, 0, 0, 4'd0);           // SUBS 3-7
        check("sub_flags", cpsr_flags, 4'b0100);
        issue(4'h4, 5'd4, 0, 4'd6, 32'd1, 32'd1, 0, 0, 4'd0);           // ADDMI
        issue(4'h5, 5'd4, 0, 4'd6, 32'd1, 32'd1, 0, 0, 4'd0);           // ADDPL skipped
        load_flags(4'b1010);
        issue(4'hE, 5'd0, 1, 4'd7, 32'h38, 32'h07, 0, 0, 4'd0);         // ANDS -> 0
        check("and_flags", cpsr_flags, 4'b1011);
        issue(4'hE, 5'd4, 1, 4'd8, 32'd5, 32'd6, 0, 1, 4'b0110);        // cpsr_we wins
        issue(4'hE, 5'd5, 1, 4'd9, 32'd1, 32'd2, 0, 0, 4'd0);           // illegal
        issue(4'hE, 5'd20, 1, 4'd9, 32'd1, 32'd2, 0, 0, 4'd0);          // illegal 1xxxx
        issue(4'hF, 5'd13, 1, 4'd9, 32'd1, 32'd2, 0, 0, 4'd0);          // never
        issue(4'hF, 5'd6, 1, 4'd9, 32'd1, 32'd2, 0, 0, 4'd0);           // illegal beats skipped
        issue(4'hE, 5'd4, 1, 4'd3, 32'd1, 32'd1, 2, 0, 4'd0);           // flush in EXEC
        issue(4'hE, 5'd4, 1, 4'd3, 32'hFFFF_FFFF, 32'd1, 3, 0, 4'd0);   // flush in WB
        issue(4'hE, 5'd13, 0, 4'd4, 32'd0, 32'h77, 1, 0, 4'd0);         // flush in IDLE ignored

        // in_valid held high: in_ready goes 1,0,0,1,0,0,1
        in_valid = 1'b1; in_cond = 4'hE; in_opcode = 5'd13; in_setflags = 1'b0;
        in_rd = 4'd11; in_op1 = 32'd0; in_op2 = 32'h1234;
        for (int i = 0; i < 7; i++) begin
            check("ready_pattern", in_ready, (i % 3) == 0);
            if (i == 6) in_valid = 1'b0;
            @(negedge clk);
        end
        check("ready_pattern_flags", cpsr_flags, mflags);

        for (int i = 0; i < 60; i++) begin
            ropc  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 12)];
            rcond = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
            ra    = $urandom;
            rb    = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            rfl   = $urandom_range(0, 11);
            rfl   = (rfl < 3) ? rfl + 1 : 0;
            issue(rcond, ropc, 1'($urandom), 4'($urandom), ra, rb, rfl,
                  ($urandom_range(0, 7) == 0), 4'($urandom));
        end

        // Reset in the middle of WB
        load_flags(4'b0101);
        in_valid = 1'b1; in_cond = 4'hE; in_opcode = 5'd4; in_setflags = 1'b1;
        in_rd = 4'd3; in_op1 = 32'd1; in_op2 = 32'd1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pre_reset_wb_en", wb_en, 1);
        rst_n = 1'b0;
        #1;
        mflags = 4'd0;
        check("reset_wb_en", wb_en, 0);
        check("reset_cpsr", cpsr_flags, 4'd0);
        check("reset_ready", in_ready, 1);
        check("reset_wb_data", wb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_cpsr", cpsr_flags, mflags);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing controller in front of the data-processing ALU. Accepts one decoded ARM data-processing instruction at a time over a valid/ready handshake, checks its condition field against the NZCV flags it owns, and drives the ALU for one execute cycle. It then writes the result back to the register file and updates the flags per the S bit and opcode class. It sits between decode and the ALU/register-file write port.

## Interface
- DATA_W, 32, operand/result width
- REG_ADDR_W, 4, register-file address width
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-low; all state cleared while low
- in_valid / in_ready  in / out  1 / 1  instruction handshake; transfer when both high on a clk edge
- in_cond  in  4  ARM condition field
- in_opcode  in  5  ALU operation code (ALU encoding)
- in_setflags  in  1  S bit
- in_rd  in  REG_ADDR_W  destination register
- in_op1, in_op2  in  DATA_W  operands (op2 already shifted/immediate)
- flush  in  1  synchronous abort of the in-flight instruction
- cpsr_we, cpsr_wdata  in  1, 4  direct flag load (MSR path)
- alu_execute  out  1  high only in EXEC with condition pass and legal opcode
- alu_data1, alu_data2, alu_operation  out  DATA_W, DATA_W, 5  latched operands/opcode, held from accept until next accept
- alu_result, alu_flags  in  DATA_W, 4  combinational ALU outputs; flags bit0 Z, bit1 C, bit2 N, bit3 V
- wb_en, wb_addr, wb_data  out  1, REG_ADDR_W, DATA_W  register write strobe (1-cycle pulse)
- cpsr_flags  out  4  current flags, same bit order as alu_flags
- skipped, illegal  out  1, 1  1-cycle status pulses in WB

## Operation
- FSM: IDLE -> EXEC -> WB -> IDLE. in_ready = (state == IDLE). Accept latches all in_* fields.
- EXEC: evaluate latched cond vs cpsr_flags: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
- Legal opcodes: 00000–00100, 01000–01111. Others (00101–00111, 1xxxx) are illegal.
- End of EXEC: register alu_result and alu_flags, the pass bit and the illegal bit.
- WB, pass and legal:
  - Writing ops (not 01000–01011): wb_en=1, wb_data = registered result.
  - Compare/test ops 01000–01011: no write; flags always updated.
  - Other ops update flags only if in_setflags.
  - Flag update always takes N, Z. C, V are taken only for arithmetic ops (00010, 00011, 00100, 01010, 01011); they are preserved for logical ops.
- WB, condition fail: skipped=1, no write, no flag change. Illegal: illegal=1, no write, no flag change; illegal takes precedence over skipped.
- cpsr_we loads cpsr_wdata in any state. If it coincides with a WB flag update, cpsr_we wins.
- flush in EXEC or WB: next state IDLE; wb_en, flag update and status pulses are suppressed that cycle. flush in IDLE: no effect; a same-cycle handshake is still accepted.

## Timing
- Accept at edge T. EXEC is cycle T..T+1. WB pulses occupy cycle T+1..T+2. New flags are visible on cpsr_flags after edge T+2. in_ready is high again in cycle T+2.
- Throughput: one instruction per 3 cycles. A back-to-back dependent condition sees the previous instruction's flags.
- ALU is combinational; the controller adds no bypass. Results and flags are registered at the end of EXEC.
- Reset values: state IDLE (in_ready=1), cpsr_flags=0000, wb_en=0, wb_addr=0, wb_data=0, alu_execute=0, alu_data1/2=0, alu_operation=0, skipped=0, illegal=0.
- Reset asserted mid-EXEC/WB clears outputs immediately. The instruction is lost with no write.

## Structure
- Shared package alu_ctrl_pkg holds: opcode constants (AND..MVN), condition-code constants, flag bit indices (FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3), FSM state enum, and an is_compare/is_arith/is_legal classification.
- One sub-module, cond_check: combinational cond (4) + flags (4) -> pass.

## Test plan
- ADD AL, S=1, op1=3, op2=7, rd=2 -> wb_en one cycle later than EXEC, wb_addr=2, wb_data=10, cpsr N=0 Z=0.
- CMP AL 7,7 -> no wb_en, cpsr Z=1. Then MOV EQ op2=0x55 rd=5 -> wb 0x55. Then MOV NE -> skipped=1, no wb.
- SUB AL S=1 3-7 rd=1 -> wb_data=0xFFFFFFFC, N=1. Then ADD MI 1+1 -> wb 2. ADD PL -> skipped.
- cpsr_we=1, cpsr_wdata=1010 (C=1, V=1). Then AND S=1 0x38&0x07 -> wb 0, Z=1, C=1 and V=1 preserved. cpsr_we concurrent with WB flag update -> cpsr_wdata wins.
- opcode 00101 -> illegal=1, no wb, flags unchanged. cond 1111 -> skipped=1. in_valid held high -> in_ready toggles 1,0,0,1 pattern.
- flush in EXEC of ADD -> no wb_en, flags unchanged, in_ready=1 next cycle. reset low during WB -> wb_en=0 immediately, cpsr_flags=0000.
